axi_store_slave: RTL
====================

# axi_store_slave

AXI-style write-channel target that consumes the store path's AW/W stream and commits 64-bit beats into a local word-addressed memory. It sits directly downstream of the LSU store buffer, in place of the external memory port. It returns one B response per W beat, tagged with that beat's on-chip RAM (oram) address, so the store buffer can selectively resend failed beats. It supports one outstanding burst, byte strobes, INCR/FIXED bursts and a bench-controlled error-injection port.

## Interface
- `ADDR_WIDTH`, default 10: byte-address width; memory depth is 2**(ADDR_WIDTH-3) 64-bit words.
- `DATA_WIDTH`, default 64: W data width; only 64 is supported.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `axi_awvld`  in  1  AW valid.
- `axi_awrdy`  out  1  AW ready.
- `axi_awid`  in  8  burst ID.
- `axi_awaddr`  in  ADDR_WIDTH  byte start address.
- `axi_awlen`  in  8  beats minus 1.
- `axi_awsize`  in  3  log2 bytes per beat.
- `axi_awburst`  in  2  00 FIXED, 01 INCR, others unsupported.
- `axi_wvld`  in  1  W valid.
- `axi_wrdy`  out  1  W ready.
- `axi_wdata`  in  64  beat data.
- `axi_wstrb`  in  8  byte enables.
- `axi_wlast`  in  1  ignored; the beat count governs.
- `axi_w_oram_addr`  in  12  source SRAM address of the beat.
- `axi_bvld`  out  1  B valid.
- `axi_brdy`  in  1  B ready.
- `axi_bresp`  out  2  00 OKAY, 10 SLVERR.
- `axi_bid`  out  8  captured awid.
- `axi_b_oram_addr`  out  12  oram address of the beat being answered.
- `err_inj_vld`  in  1  arm single-shot error injection.
- `err_inj_oram_addr`  in  12  beat oram address to fail.
- `dbg_raddr`  in  ADDR_WIDTH-3  bench word read address.
- `dbg_rdata`  out  64  combinational memory read.

## Operation
- FSM states: IDLE, DATA, DRAIN.
- **IDLE**
  - `axi_awrdy`=1.
  - On AW handshake, capture id, addr, len, size and burst; clear the beat counter; go to DATA.
- **Burst error flag**
  - Set at AW handshake if awsize≠3 or awburst∉{00,01}.
  - When set, every beat of the burst returns SLVERR and writes nothing.
- **DATA**
  - `axi_wrdy` = !axi_bvld | axi_brdy.
  - On a W handshake:
    - Write the memory word at addr[ADDR_WIDTH-1:3], byte i only where wstrb[i]=1, unless the beat errs.
    - Load the B register: bvld=1, bid, b_oram_addr = w_oram_addr, bresp.
    - Beat counter +1.
  - INCR: the address advances by 8 each beat and wraps modulo 2**ADDR_WIDTH. FIXED: the address is held.
  - After the beat where counter == awlen, go to DRAIN.
- **DRAIN**
  - wrdy=0.
  - Once the final B handshakes (bvld & brdy), go to IDLE.
- **B channel**
  - bvld clears on handshake unless a new W beat reloads it in the same cycle.
  - bvld is held while brdy=0; no beat is lost or duplicated.
- **Error injection**
  - err_inj_vld pulse latches the address and arms the injector; a new pulse overwrites it.
  - The first W beat whose w_oram_addr matches returns SLVERR and skips its write; the injector then disarms.
- **Misuse**
  - axi_wvld in IDLE or DRAIN is not accepted (wrdy=0).
  - axi_awvld outside IDLE waits (awrdy=0).

## Timing
- Reset values:
  - awrdy=0, wrdy=0, bvld=0, bresp=0, bid=0, b_oram_addr=0.
  - FSM = IDLE; injector disarmed.
  - Memory is not reset.
- awrdy rises the first cycle after rst_n deasserts.
- AW handshake at cycle T → wrdy may be 1 at T+1.
- W handshake at T → memory updated at the T edge (visible on dbg_rdata at T+1); bvld=1 at T+1.
- Throughput is 1 beat/cycle with brdy held 1.
- With brdy=0, at most one unanswered beat exists; wrdy drops until the B handshake.
- Final B handshake at T → IDLE and awrdy=1 at T+1.
- Simultaneous B handshake and new W handshake in the same cycle: the B register reloads, and bvld stays 1.
- awlen=0: the single beat goes directly to DRAIN.
- awlen=255: the counter is 8-bit; the compare on ==awlen terminates with no overflow.
- Reset asserted mid-burst: immediate return to the reset values; the partial burst is abandoned, and memory writes already done remain.

## Test plan
- **Single beat:** AW {id=3, addr=0x010, len=0, size=3, INCR}, W {data=0x1122334455667788, strb=FF, oram=0x005} → mem[2]=0x1122334455667788; B {OKAY, id=3, oram=0x005} one cycle after the W handshake.
- **INCR burst with back-pressure:** len=3, addr=0x3F0 (wraps to word 0), brdy toggling 1/0 → words 126, 127, 0, 1 written; 4 B responses in order; wrdy=0 whenever bvld&!brdy.
- **Strobes/FIXED:** FIXED len=1 at 0x008, strb 0x0F then 0xF0 → word 1 holds the low half of beat 0 and the high half of beat 1.
- **Unsupported:** awsize=2, len=1 → 2 SLVERR responses; memory unchanged. Then a legal burst → OKAY.
- **Injection/resend:** arm oram=0x042; burst of 4 beats with oram 0x040–0x043 → only the 0x042 beat returns SLVERR and is unwritten. Resend that beat as a new len=0 burst → OKAY and written.
- **Reset mid-burst:** rst_n low after 2 of 4 beats → all outputs 0, awrdy=1 one cycle after release; a new burst completes normally.

Source files
------------

// File: rtl/axi_store_slave.sv
// rtl/axi_store_slave.sv - AXI-style write target committing 64-bit beats to local memory, one B per W beat
module axi_store_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    axi_awvld,
    output logic                    axi_awrdy,
    input  logic [7:0]              axi_awid,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [7:0]              axi_awlen,
    input  logic [2:0]              axi_awsize,
    input  logic [1:0]              axi_awburst,
    input  logic                    axi_wvld,
    output logic                    axi_wrdy,
    input  logic [DATA_WIDTH-1:0]   axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                    axi_wlast,
    input  logic [11:0]             axi_w_oram_addr,
    output logic                    axi_bvld,
    input  logic                    axi_brdy,
    output logic [1:0]              axi_bresp,
    output logic [7:0]              axi_bid,
    output logic [11:0]             axi_b_oram_addr,
    input  logic                    err_inj_vld,
    input  logic [11:0]             err_inj_oram_addr,
    input  logic [ADDR_WIDTH-4:0]   dbg_raddr,
    output logic [DATA_WIDTH-1:0]   dbg_rdata
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 3);
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic                    awrdy_q, awrdy_d;
    logic [7:0]              id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic                    burst_err_q, burst_err_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    bvld_q, bvld_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [7:0]              bid_q, bid_d;
    logic [11:0]             boram_q, boram_d;
    logic                    inj_armed_q, inj_armed_d;
    logic [11:0]             inj_addr_q, inj_addr_d;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    wrdy;
    logic                    inj_hit;
    logic                    beat_err;
    logic                    mem_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // The captured size only feeds the error flag; wlast is ignored because the beat count governs.
    logic unused_sigs;
    assign unused_sigs = ^{axi_wlast, size_q};

    always_comb begin
        aw_hs    = axi_awvld && awrdy_q && (state_q == ST_IDLE);
        wrdy     = (state_q == ST_DATA) && (!bvld_q || axi_brdy);
        w_hs     = axi_wvld && wrdy;
        b_hs     = bvld_q && axi_brdy;
        inj_hit  = inj_armed_q && (axi_w_oram_addr == inj_addr_q);
        beat_err = burst_err_q || inj_hit;
        mem_we   = w_hs && !beat_err;
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        burst_err_d = burst_err_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    id_d        = axi_awid;
                    addr_d      = axi_awaddr;
                    len_d       = axi_awlen;
                    size_d      = axi_awsize;
                    burst_d     = axi_awburst;
                    burst_err_d = (axi_awsize != 3'd3) || axi_awburst[1];
                    cnt_d       = 8'd0;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    cnt_d = cnt_q + 8'd1;
                    if (burst_q == BURST_INCR) begin
                        addr_d = addr_q + ADDR_WIDTH'(8);
                    end
                    // Compare before increment so len=255 ends without the counter overflowing first.
                    if (cnt_q == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (b_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        awrdy_d = (state_d == ST_IDLE);
    end

    always_comb begin
        bvld_d  = bvld_q;
        bresp_d = bresp_q;
        bid_d   = bid_q;
        boram_d = boram_q;
        if (w_hs) begin
            bvld_d  = 1'b1;
            bresp_d = beat_err ? RESP_SLVERR : RESP_OKAY;
            bid_d   = id_q;
            boram_d = axi_w_oram_addr;
        end else if (b_hs) begin
            bvld_d = 1'b0;
        end
    end

    always_comb begin
        inj_armed_d = inj_armed_q;
        inj_addr_d  = inj_addr_q;
        if (err_inj_vld) begin
            inj_armed_d = 1'b1;
            inj_addr_d  = err_inj_oram_addr;
        end else if (w_hs && inj_hit) begin
            inj_armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            awrdy_q     <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            burst_err_q <= 1'b0;
            cnt_q       <= '0;
            bvld_q      <= 1'b0;
            bresp_q     <= '0;
            bid_q       <= '0;
            boram_q     <= '0;
            inj_armed_q <= 1'b0;
            inj_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            awrdy_q     <= awrdy_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            burst_err_q <= burst_err_d;
            cnt_q       <= cnt_d;
            bvld_q      <= bvld_d;
            bresp_q     <= bresp_d;
            bid_q       <= bid_d;
            boram_q     <= boram_d;
            inj_armed_q <= inj_armed_d;
            inj_addr_q  <= inj_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (axi_wstrb[i]) begin
                    mem[addr_q[ADDR_WIDTH-1:3]][8*i +: 8] <= axi_wdata[8*i +: 8];
                end
            end
        end
    end

    assign axi_awrdy       = awrdy_q;
    assign axi_wrdy        = wrdy;
    assign axi_bvld        = bvld_q;
    assign axi_bresp       = bresp_q;
    assign axi_bid         = bid_q;
    assign axi_b_oram_addr = boram_q;
    assign dbg_rdata       = mem[dbg_raddr];

endmodule
